// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and MEM-stage state encoding
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  logic                  ld_rdata,
  input  logic                  regwrite,
  input  logic                  memtoreg,
  input  logic [WORD_W-1:0]     aluout,
  input  logic [WORD_W-1:0]     rdata,
  input  logic [REG_ADDR_W-1:0] writereg,
  output logic                  regwritew,
  output logic                  memtoregw,
  output logic [WORD_W-1:0]     readdataw,
  output logic [WORD_W-1:0]     aluoutw,
  output logic [REG_ADDR_W-1:0] writeregw
);
  logic regwrite_d, regwrite_q, memtoreg_d, memtoreg_q;
  logic [WORD_W-1:0] readdata_d, readdata_q, aluout_d, aluout_q;
  logic [REG_ADDR_W-1:0] writereg_d, writereg_q;
  always_comb begin
    regwrite_d = bubble ? 1'b0 : regwrite;
    memtoreg_d = bubble ? 1'b0 : memtoreg;
    aluout_d = bubble ? aluout_q : aluout;
    writereg_d = bubble ? writereg_q : writereg;
    readdata_d = (!bubble && ld_rdata) ? rdata : readdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      readdata_q <= '0;
      aluout_q <= '0;
      writereg_q <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      readdata_q <= readdata_d;
      aluout_q <= aluout_d;
      writereg_q <= writereg_d;
    end
  end
  assign regwritew = regwrite_q;
  assign memtoregw = memtoreg_q;
  assign readdataw = readdata_q;
  assign aluoutw = aluout_q;
  assign writeregw = writereg_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with req/ack data memory, stall and timeout
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regwritem,
  input  logic                  memtoregm,
  input  logic                  memwritem,
  input  logic [WORD_W-1:0]     aluoutm,
  input  logic [WORD_W-1:0]     writedatam,
  input  logic [REG_ADDR_W-1:0] writeregm,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_W-1:0]     dmem_addr,
  output logic [WORD_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [WORD_W-1:0]     dmem_rdata,
  output logic                  stallm,
  output logic                  regwritew,
  output logic                  memtoregw,
  output logic [WORD_W-1:0]     readdataw,
  output logic [WORD_W-1:0]     aluoutw,
  output logic [REG_ADDR_W-1:0] writeregw,
  output logic                  bus_err,
  output logic                  align_err
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic we_q, we_d, bus_err_q, bus_err_d, align_err_q, align_err_d;
  logic memop, misaligned, busy, timeout_hit;
  always_comb begin
    memop = memtoregm | memwritem;
    misaligned = memop & (aluoutm[1:0] != 2'b00);
    busy = state_q == BUSY;
    dmem_req = !reset & (busy | (memop & !misaligned));
    timeout_hit = busy & !dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    stallm = dmem_req & !dmem_ack & !timeout_hit;
    dmem_addr = busy ? addr_q : aluoutm;
    dmem_we = busy ? we_q : memwritem;
    dmem_wdata = busy ? wdata_q : writedatam;
    state_d = stallm ? BUSY : IDLE;
    cnt_d = stallm ? cnt_q + 1'b1 : '0;
    addr_d = dmem_addr;
    we_d = dmem_we;
    wdata_d = dmem_wdata;
    bus_err_d = bus_err_q | timeout_hit;
    align_err_d = align_err_q | misaligned;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      bus_err_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      bus_err_q <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end
  assign bus_err = bus_err_q;
  assign align_err = align_err_q;
  mem_wb_reg u_mem_wb (
    .clk       (clk),
    .reset     (reset),
    .bubble    (stallm | misaligned | timeout_hit),
    .ld_rdata  (memtoregm & dmem_req & dmem_ack),
    .regwrite  (regwritem),
    .memtoreg  (memtoregm),
    .aluout    (aluoutm),
    .rdata     (dmem_rdata),
    .writereg  (writeregm),
    .regwritew (regwritew),
    .memtoregw (memtoregw),
    .readdataw (readdataw),
    .aluoutw   (aluoutw),
    .writeregw (writeregw)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: random instruction/latency stream checked against a transaction-level model
module tb_mem_access_stage;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset, regwritem, memtoregm, memwritem, dmem_ack;
  logic [31:0] aluoutm, writedatam, dmem_rdata;
  logic [4:0] writeregm;
  logic dmem_req, dmem_we, stallm, regwritew, memtoregw, bus_err, align_err;
  logic [31:0] dmem_addr, dmem_wdata, readdataw, aluoutw;
  logic [4:0] writeregw;
  logic exp_bus = 1'b0, exp_align = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .regwritem(regwritem), .memtoregm(memtoregm),
    .memwritem(memwritem), .aluoutm(aluoutm), .writedatam(writedatam),
    .writeregm(writeregm), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stallm(stallm), .regwritew(regwritew),
    .memtoregw(memtoregw), .readdataw(readdataw), .aluoutw(aluoutw),
    .writeregw(writeregw), .bus_err(bus_err), .align_err(align_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rw, input logic mtr, input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] wr);
    regwritem = rw;
    memtoregm = mtr;
    memwritem = mw;
    aluoutm = a;
    writedatam = wd;
    writeregm = wr;
  endtask
  task automatic chk_wb_clear(input string tag);
    chk({tag, "_regwritew"}, regwritew, 0);
    chk({tag, "_memtoregw"}, memtoregw, 0);
    chk({tag, "_readdataw"}, readdataw, 0);
    chk({tag, "_aluoutw"}, aluoutw, 0);
    chk({tag, "_writeregw"}, writeregw, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
    chk({tag, "_align_err"}, align_err, 0);
  endtask
  // kind: 0 ALU, 1 load, 2 store, 3 misaligned memop; lat: ack delay in cycles after the request cycle
  task automatic run_instr(input int kind, input int lat);
    logic [31:0] a, wd, rd;
    logic [4:0] wr;
    logic rw, mtr, mw, req, mis, ok, noise;
    int stalls;
    a = $urandom;
    wd = $urandom;
    wr = 5'($urandom);
    rw = 1'($urandom);
    rd = '0;
    mtr = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
    mw = (kind == 2) || (kind == 3 && !mtr);
    if (kind == 1 || kind == 2) a[1:0] = 2'b00;
    if (kind == 3) a[1:0] = 2'($urandom_range(1, 3));
    mis = kind == 3;
    req = kind == 1 || kind == 2;
    stalls = req ? (lat < TO ? lat : TO) : 0;
    ok = req && lat <= TO;
    noise = kind == 0 && $urandom_range(0, 1) == 1;
    drive(rw, mtr, mw, a, wd, wr);
    for (int c = 0; c <= stalls; c++) begin
      dmem_ack = req ? (c == lat) : (noise && c == 0);
      dmem_rdata = $urandom;
      if (dmem_ack) rd = dmem_rdata;
      #1;
      chk("dmem_req", dmem_req, req);
      chk("stallm", stallm, c < stalls);
      if (req) begin
        chk("dmem_addr", dmem_addr, a);
        chk("dmem_we", dmem_we, mw);
        chk("dmem_wdata", dmem_wdata, wd);
      end
      tick();
    end
    dmem_ack = 1'b0;
    exp_bus = exp_bus | (req && !ok);
    exp_align = exp_align | mis;
    chk("regwritew", regwritew, (req ? ok : !mis) & rw);
    chk("memtoregw", memtoregw, ok & mtr);
    if (!mis && (ok || !req)) begin
      chk("aluoutw", aluoutw, a);
      chk("writeregw", writeregw, wr);
    end
    if (ok && mtr) chk("readdataw", readdataw, rd);
    chk("bus_err", bus_err, exp_bus);
    chk("align_err", align_err, exp_align);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("req_after", dmem_req, 0);
    chk("stall_after", stallm, 0);
  endtask
  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(1, 1, 0, 32'h100, 32'h55, 5'd7);
    tick();
    tick();
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stallm, 0);
    chk_wb_clear("rst");
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    run_instr(0, 0);
    run_instr(1, 0);
    run_instr(2, 3);
    run_instr(1, TO + 1);
    run_instr(3, 0);
    run_instr(1, TO);
    run_instr(2, TO + 2);
    for (int i = 0; i < 200; i++) run_instr($urandom_range(0, 3), $urandom_range(0, TO + 2));
    drive(1, 1, 0, 32'h240, 0, 5'd3);
    #1;
    chk("mid_stall0", stallm, 1);
    tick();
    chk("mid_stall1", stallm, 1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    exp_bus = 1'b0;
    exp_align = 1'b0;
    chk_wb_clear("midrst");
    chk("midrst_req", dmem_req, 0);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = $urandom;
    #1;
    chk("late_req", dmem_req, 0);
    chk("late_stall", stallm, 0);
    tick();
    dmem_ack = 1'b0;
    chk_wb_clear("late");
    run_instr(1, 0);
    run_instr(2, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs and runs loads and stores against data memory over a req/ack handshake. While an access is outstanding it stalls the upstream pipeline. It owns the MEM/WB pipeline register that feeds write-back.

Parameters:
TIMEOUT_CYCLES, 255, max cycles an access waits for dmem_ack before it is aborted
CNT_W, 8, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
regwritem  in  1  EX/MEM register-write control
memtoregm  in  1  EX/MEM load indicator
memwritem  in  1  EX/MEM store indicator
aluoutm  in  32  EX/MEM effective address / ALU result
writedatam  in  32  EX/MEM store data
writeregm  in  5  EX/MEM destination register
dmem_req  out  1  data memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  32  word address (byte address, [1:0]=0)
dmem_wdata  out  32  store data
dmem_ack  in  1  memory completion, one-cycle pulse
dmem_rdata  in  32  read data; valid in the dmem_ack cycle
stallm  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
regwritew  out  1  MEM/WB register-write control
memtoregw  out  1  MEM/WB load indicator
readdataw  out  32  MEM/WB load data
aluoutw  out  32  MEM/WB ALU result
writeregw  out  5  MEM/WB destination register
bus_err  out  1  sticky: an access timed out
align_err  out  1  sticky: a misaligned load/store was dropped

Behaviour:
- Reset is synchronous, active-high. All registered outputs clear to 0: regwritew, memtoregw, readdataw, aluoutw, writeregw, bus_err, align_err. State goes to IDLE and the counter to 0.
- While reset is high, dmem_req=0 and stallm=0.
- memop = memtoregm | memwritem. misaligned = memop & (aluoutm[1:0] != 0).
- States:
  - IDLE: no access outstanding.
  - BUSY: request issued, waiting for ack.
- dmem_req is combinational: 1 when (IDLE & memop & !misaligned) or in BUSY.
- In the IDLE request cycle, dmem_addr, dmem_we and dmem_wdata come directly from aluoutm, memwritem and writedatam. On entry to BUSY these are latched, and in BUSY they are driven from the latch. They stay stable until ack.
- stallm = dmem_req & !dmem_ack & !timeout_hit.
- Zero-wait memory: an ack in the IDLE request cycle completes the access in 1 cycle. No stall, and the state stays IDLE.
- IDLE -> BUSY when there is a request and no ack. The counter is 1 on entry and increments each BUSY cycle.
- BUSY -> IDLE on dmem_ack. This is the completion cycle: stallm=0, and MEM/WB loads the instruction.
- timeout_hit = BUSY & !dmem_ack & counter == TIMEOUT_CYCLES. On timeout_hit:
  - BUSY -> IDLE and stallm=0.
  - MEM/WB loads a bubble.
  - bus_err is set.
  - dmem_req drops next cycle.
- Ack and timeout in the same cycle: the ack wins.
- dmem_ack while dmem_req=0 is ignored.
- MEM/WB update rule:
  - When stallm=1, a bubble is loaded: regwritew=0, memtoregw=0, other fields don't-care (hold).
  - Otherwise the EX/MEM fields are loaded, and readdataw takes dmem_rdata when a load completes.
- Misaligned memop: no request and no stall. A bubble is loaded and align_err is set.
- Non-memory instructions pass EX/MEM to MEM/WB with 1-cycle latency.
- Upstream contract: the EX/MEM register holds its contents while stallm=1.
- Reset mid-BUSY: the access is abandoned, no error flag is set, and a late ack is ignored.
- Sticky flags clear only on reset.

Decomposition:
- Shared package mips_pkg:
  - state encoding (IDLE=1'b0, BUSY=1'b1)
  - WORD_W=32
  - REG_ADDR_W=5
- One natural sub-module: mem_wb_reg, the MEM/WB register with a bubble input.
- The FSM, counter and handshake stay in mem_access_stage.

Test Plan:
- ALU op (regwritem=1, aluoutm=0x0000_0010, writeregm=5, no memop) -> next cycle regwritew=1, aluoutw=0x10, writeregw=5; dmem_req and stallm never rise.
- Load, ack in the same cycle (aluoutm=0x100, dmem_rdata=0xDEADBEEF) -> no stall; next cycle readdataw=0xDEADBEEF, memtoregw=1.
- Store, ack after 3 wait cycles (addr=0x200, wdata=0x1234) -> stallm high 3 cycles; dmem_addr/wdata stable throughout; dmem_we=1; regwritew=0 during the stall and after completion.
- Load with no ack, TIMEOUT_CYCLES=4 -> stallm high 4 cycles, then 0; bus_err=1 stays set; regwritew=0 for that instruction; dmem_req low the next cycle.
- Load at aluoutm=0x102 -> dmem_req stays 0, no stall; align_err=1; next cycle regwritew=0.
- Reset asserted in BUSY, then ack 2 cycles later -> all outputs 0, state IDLE; the late ack causes no MEM/WB update and no error flag.
